// File: rtl/sipo_capture.sv
// sipo_capture: serial-in/parallel-out capture into a one-deep valid/ready holding register.
// Rev 1.0
`default_nettype none

module sipo_capture #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sin,
  input  logic             msb_first,
  input  logic             clr,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  input  logic             pready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ord_q, ord_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pvalid_q, pvalid_d;
  logic             ovr_q, ovr_d;

  logic             w_ord;
  logic             w_last;
  logic             w_done;
  logic [WIDTH-1:0] w_shift;

  // The first bit of a word uses msb_first directly, before ord has latched it.
  assign w_ord   = (cnt_q == '0) ? msb_first : ord_q;
  assign w_shift = w_ord ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
  assign w_last  = (cnt_q == C_LAST);
  assign w_done  = en & ~clr & w_last;

  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    ord_d    = ord_q;
    pout_d   = pout_q;
    pvalid_d = pvalid_q;
    ovr_d    = ovr_q;

    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
      ovr_d = 1'b0;
    end else if (en) begin
      if (cnt_q == '0) ord_d = msb_first;
      if (w_last) begin
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        sr_d  = w_shift;
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (w_done) begin
      if (!pvalid_q || pready) begin
        pout_d   = w_shift;
        pvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (pvalid_q && pready) begin
      pvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      ord_q    <= 1'b1;
      pout_q   <= '0;
      pvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      ord_q    <= ord_d;
      pout_q   <= pout_d;
      pvalid_q <= pvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign pout    = pout_q;
  assign pvalid  = pvalid_q;
  assign bit_cnt = cnt_q;
  assign overrun = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_capture.sv
// tb_sipo_capture: directed self-checking bench for sipo_capture (WIDTH=8).
// Rev 1.0
`default_nettype none

module tb_sipo_capture;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       sin;
  logic       msb_first;
  logic       clr;
  logic [7:0] pout;
  logic       pvalid;
  logic       pready;
  logic [2:0] bit_cnt;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  sipo_capture #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sin       (sin),
    .msb_first (msb_first),
    .clr       (clr),
    .pout      (pout),
    .pvalid    (pvalid),
    .pready    (pready),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream byte s is sent s[7] first; mo0 is the order for bit 0, mo_rest for the others.
  task automatic send_stream(input logic [7:0] s, input logic mo0, input logic mo_rest,
                             input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      en        = 1'b1;
      sin       = s[7-i];
      msb_first = (i == 0) ? mo0 : mo_rest;
      pready    = (i == 7) ? rdy_last : 1'b0;
      tick();
    end
    en     = 1'b0;
    pready = 1'b0;
  endtask

  task automatic consume();
    pready = 1'b1;
    tick();
    pready = 1'b0;
  endtask

  initial begin
    logic [7:0] gap_w;
    logic [7:0] stream_w [4];
    stream_w[0] = 8'h01; stream_w[1] = 8'h80; stream_w[2] = 8'hFF; stream_w[3] = 8'h00;
    gap_w = 8'hA5;

    rst_n = 1'b0; en = 1'b0; sin = 1'b0; msb_first = 1'b1; clr = 1'b0; pready = 1'b0;
    repeat (3) tick();
    check_eq("rst_pout", pout, 8'h00);
    check_eq("rst_pvalid", pvalid, 1'b0);
    check_eq("rst_bitcnt", bit_cnt, 3'd0);
    check_eq("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    tick();

    // Bit order
    send_stream(8'hC0, 1'b1, 1'b1, 1'b0);
    check_eq("msb_pout", pout, 8'hC0);
    check_eq("msb_pvalid", pvalid, 1'b1);
    check_eq("msb_bitcnt", bit_cnt, 3'd0);
    consume();
    check_eq("consume_pvalid", pvalid, 1'b0);
    check_eq("consume_pout_hold", pout, 8'hC0);
    send_stream(8'hC0, 1'b0, 1'b0, 1'b0);
    check_eq("lsb_pout", pout, 8'h03);
    check_eq("lsb_pvalid", pvalid, 1'b1);
    consume();
    send_stream(8'hC0, 1'b0, 1'b1, 1'b0);
    check_eq("toggle_lsb_pout", pout, 8'h03);
    consume();
    send_stream(8'hC0, 1'b1, 1'b0, 1'b0);
    check_eq("toggle_msb_pout", pout, 8'hC0);
    consume();

    // Gaps: en=0 for 3 cycles between bits, sin/msb_first wiggling meanwhile
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; sin = gap_w[7-i]; msb_first = 1'b1;
      tick();
      en = 1'b0;
      check_eq("gap_bitcnt", bit_cnt, (i == 7) ? 3'd0 : 3'(i + 1));
      for (int g = 0; g < 3; g++) begin
        sin = 1'($urandom_range(0, 1));
        msb_first = 1'($urandom_range(0, 1));
        tick();
      end
      check_eq("gap_bitcnt_hold", bit_cnt, (i == 7) ? 3'd0 : 3'(i + 1));
      check_eq("gap_pvalid", pvalid, (i == 7) ? 1'b1 : 1'b0);
    end
    check_eq("gap_pout", pout, 8'hA5);
    consume();

    // clr aborts a partial word
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; sin = 1'b1; msb_first = 1'b1;
      tick();
    end
    check_eq("pre_clr_bitcnt", bit_cnt, 3'd4);
    clr = 1'b1; sin = 1'b0;
    tick();
    clr = 1'b0; en = 1'b0;
    check_eq("clr_bitcnt", bit_cnt, 3'd0);
    check_eq("clr_pvalid", pvalid, 1'b0);
    send_stream(8'h5A, 1'b1, 1'b1, 1'b0);
    check_eq("post_clr_pout", pout, 8'h5A);
    check_eq("post_clr_pvalid", pvalid, 1'b1);
    consume();

    // Simultaneous consume on the completing edge
    send_stream(8'hC0, 1'b1, 1'b1, 1'b0);
    send_stream(8'h3C, 1'b1, 1'b1, 1'b1);
    check_eq("simul_pout", pout, 8'h3C);
    check_eq("simul_pvalid", pvalid, 1'b1);
    check_eq("simul_overrun", overrun, 1'b0);
    consume();

    // Overrun
    send_stream(8'h11, 1'b1, 1'b1, 1'b0);
    send_stream(8'h22, 1'b1, 1'b1, 1'b0);
    check_eq("ovr_pout", pout, 8'h11);
    check_eq("ovr_flag", overrun, 1'b1);
    check_eq("ovr_pvalid", pvalid, 1'b1);
    consume();
    check_eq("ovr_drain_pvalid", pvalid, 1'b0);
    check_eq("ovr_sticky", overrun, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("ovr_clr", overrun, 1'b0);

    // Streaming with en and pready held high
    pready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 8; i++) begin
        en = 1'b1; msb_first = 1'b1; sin = stream_w[w][7-i];
        tick();
        check_eq("stream_pvalid", pvalid, (i == 7) ? 1'b1 : 1'b0);
        if (i == 7) check_eq("stream_pout", pout, stream_w[w]);
      end
    end
    en = 1'b0;
    tick();
    pready = 1'b0;
    check_eq("stream_overrun", overrun, 1'b0);
    check_eq("stream_end_pvalid", pvalid, 1'b0);

    // Asynchronous reset mid-word with a held word
    send_stream(8'h77, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; sin = i[0]; msb_first = 1'b1;
      tick();
    end
    en = 1'b0;
    check_eq("mid_bitcnt", bit_cnt, 3'd5);
    check_eq("mid_pvalid", pvalid, 1'b1);
    rst_n = 1'b0;
    #2;
    check_eq("async_rst_pout", pout, 8'h00);
    check_eq("async_rst_pvalid", pvalid, 1'b0);
    check_eq("async_rst_bitcnt", bit_cnt, 3'd0);
    check_eq("async_rst_overrun", overrun, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    send_stream(8'h96, 1'b1, 1'b1, 1'b0);
    check_eq("post_rst_pout", pout, 8'h96);
    check_eq("post_rst_pvalid", pvalid, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
